// File: rtl/tag_way_ctrl.sv
// Tag-compare and way-select controller for a 4-way set-associative tag store.
// Holds per-set valid and 3-bit tree-PLRU state, compares the four tag-bank
// read words against the captured request tag, and steers the tag mux and
// the tag-bank write enables on hits, misses and refills.
module tag_way_ctrl #(
  parameter int unsigned TAG_W = 20,
  parameter int unsigned SET_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  input  logic [TAG_W-1:0] REQ_TAG,
  input  logic [SET_W-1:0] REQ_SET,
  input  logic [TAG_W-1:0] TAG0,
  input  logic [TAG_W-1:0] TAG1,
  input  logic [TAG_W-1:0] TAG2,
  input  logic [TAG_W-1:0] TAG3,
  input  logic             FILL_DONE,
  input  logic             INV,
  output logic             READY,
  output logic             HIT,
  output logic             MISS,
  output logic [1:0]       SEL,
  output logic [3:0]       WE
);

  localparam int unsigned NSETS = 1 << SET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic [SET_W-1:0]          set_q, set_d;
  logic [NSETS-1:0][3:0]     valid_q, valid_d;
  logic [NSETS-1:0][2:0]     plru_q, plru_d;
  logic [1:0]                sel_q, sel_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;
  logic [3:0]                we_q, we_d;

  logic [3:0]                match;
  logic [3:0]                set_valid;
  logic [2:0]                set_plru;
  logic [1:0]                hit_way;
  logic [1:0]                victim;

  // Tree-PLRU update: point the tree away from the way just touched.
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r = b;
    case (w)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  // Tag compare, lowest-index hit way, and victim choice for the captured set.
  always_comb begin
    set_valid = valid_q[set_q];
    set_plru  = plru_q[set_q];
    match[0]  = set_valid[0] && (TAG0 == tag_q);
    match[1]  = set_valid[1] && (TAG1 == tag_q);
    match[2]  = set_valid[2] && (TAG2 == tag_q);
    match[3]  = set_valid[3] && (TAG3 == tag_q);

    hit_way = 2'd0;
    if (match[0])      hit_way = 2'd0;
    else if (match[1]) hit_way = 2'd1;
    else if (match[2]) hit_way = 2'd2;
    else if (match[3]) hit_way = 2'd3;

    victim = 2'd0;
    if (!set_valid[0])      victim = 2'd0;
    else if (!set_valid[1]) victim = 2'd1;
    else if (!set_valid[2]) victim = 2'd2;
    else if (!set_valid[3]) victim = 2'd3;
    else if (!set_plru[0])  victim = set_plru[1] ? 2'd1 : 2'd0;
    else                    victim = set_plru[2] ? 2'd3 : 2'd2;
  end

  // Next-state and registered-output logic for the lookup/refill FSM.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    valid_d = valid_q;
    plru_d  = plru_q;
    sel_d   = sel_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    we_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          tag_d   = REQ_TAG;
          set_d   = REQ_SET;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|match) begin
          hit_d          = 1'b1;
          sel_d          = hit_way;
          plru_d[set_q]  = plru_touch(set_plru, hit_way);
          state_d        = S_IDLE;
        end else begin
          miss_d  = 1'b1;
          sel_d   = victim;
          state_d = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (INV) begin
          state_d = S_IDLE;
        end else if (FILL_DONE) begin
          we_d[sel_q]          = 1'b1;
          valid_d[set_q][sel_q] = 1'b1;
          plru_d[set_q]        = plru_touch(set_plru, sel_q);
          state_d              = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the case so a lookup in flight still compares against
    // the pre-clear valid bits while the clear lands on the same edge.
    if (INV) valid_d = '0;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      valid_q <= '0;
      plru_q  <= '0;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      we_q    <= we_d;
    end
  end

  assign READY = (state_q == S_IDLE);
  assign HIT   = hit_q;
  assign MISS  = miss_q;
  assign SEL   = sel_q;
  assign WE    = we_q;

endmodule

// File: tb/tb_tag_way_ctrl.sv
// Directed testbench for tag_way_ctrl with hand-computed expectations.
module tb_tag_way_ctrl;

  localparam int unsigned TAG_W = 20;
  localparam int unsigned SET_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             REQ_VALID = 1'b0;
  logic [TAG_W-1:0] REQ_TAG = '0;
  logic [SET_W-1:0] REQ_SET = '0;
  logic [TAG_W-1:0] TAG0 = '0, TAG1 = '0, TAG2 = '0, TAG3 = '0;
  logic             FILL_DONE = 1'b0;
  logic             INV = 1'b0;
  logic             READY, HIT, MISS;
  logic [1:0]       SEL;
  logic [3:0]       WE;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_seen = 0;
  logic mon_we = 1'b0;

  tag_way_ctrl #(.TAG_W(TAG_W), .SET_W(SET_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_TAG(REQ_TAG),
    .REQ_SET(REQ_SET), .TAG0(TAG0), .TAG1(TAG1), .TAG2(TAG2), .TAG3(TAG3),
    .FILL_DONE(FILL_DONE), .INV(INV), .READY(READY), .HIT(HIT), .MISS(MISS),
    .SEL(SEL), .WE(WE)
  );

  always #5 CLK = ~CLK;

  // Counts any write-enable activity while the abort scenario is monitored.
  always @(negedge CLK) if (mon_we && (WE != 4'b0000)) we_seen++;

  // Presents one request, optionally raises INV during the lookup cycle,
  // and returns what the block shows in the lookup cycle and just after it.
  task automatic do_lookup(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                           input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                           input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3,
                           input logic inv, output logic rdy_lk, output logic h,
                           output logic m, output logic [1:0] sl, output logic [3:0] w);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_SET = s; REQ_TAG = t;
    TAG0 = t0; TAG1 = t1; TAG2 = t2; TAG3 = t3;
    @(negedge CLK);
    REQ_VALID = 1'b0; INV = inv;
    rdy_lk = READY;
    @(negedge CLK);
    INV = 1'b0;
    h = HIT; m = MISS; sl = SEL; w = WE;
  endtask

  // Pulses FILL_DONE (optionally with INV) and returns the outputs after that edge.
  task automatic do_fill(input logic inv, output logic [3:0] w, output logic rdy);
    @(negedge CLK);
    FILL_DONE = 1'b1; INV = inv;
    @(negedge CLK);
    FILL_DONE = 1'b0; INV = 1'b0;
    w = WE; rdy = READY;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    total_cnt++; if (READY !== 1'b1) $display("FAIL reset_ready got %0b exp 1", READY); else pass_cnt++;
    total_cnt++; if (HIT !== 1'b0) $display("FAIL reset_hit got %0b exp 0", HIT); else pass_cnt++;
    total_cnt++; if (MISS !== 1'b0) $display("FAIL reset_miss got %0b exp 0", MISS); else pass_cnt++;
    total_cnt++; if (WE !== 4'b0000) $display("FAIL reset_we got %b exp 0000", WE); else pass_cnt++;
    total_cnt++; if (SEL !== 2'd0) $display("FAIL reset_sel got %0d exp 0", SEL); else pass_cnt++;
    RST_N = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic rl, h, m, r; logic [1:0] sl; logic [3:0] w;
    do_lookup(4'd3, 20'h12345, 20'h12345, 20'h12345, 20'h12345, 20'h12345, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (rl !== 1'b0) $display("FAIL cold_ready_lookup got %0b exp 0", rl); else pass_cnt++;
    total_cnt++; if (m !== 1'b1 || h !== 1'b0) $display("FAIL cold_miss MISS=%0b HIT=%0b exp 1/0", m, h); else pass_cnt++;
    total_cnt++; if (sl !== 2'd0) $display("FAIL cold_sel got %0d exp 0", sl); else pass_cnt++;
    total_cnt++; if (READY !== 1'b0) $display("FAIL cold_ready_wait got %0b exp 0", READY); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (MISS !== 1'b0) $display("FAIL cold_miss_pulse got %0b exp 0", MISS); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0001) $display("FAIL cold_we got %b exp 0001", w); else pass_cnt++;
    total_cnt++; if (r !== 1'b1) $display("FAIL cold_ready_fill got %0b exp 1", r); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (WE !== 4'b0000) $display("FAIL cold_we_pulse got %b exp 0000", WE); else pass_cnt++;
  endtask

  task automatic test_hit();
    logic rl, h, m; logic [1:0] sl; logic [3:0] w;
    do_lookup(4'd3, 20'h12345, 20'h12345, 20'h00001, 20'h00002, 20'h00003, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || m !== 1'b0) $display("FAIL hit HIT=%0b MISS=%0b exp 1/0", h, m); else pass_cnt++;
    total_cnt++; if (sl !== 2'd0) $display("FAIL hit_sel got %0d exp 0", sl); else pass_cnt++;
    total_cnt++; if (w !== 4'b0000) $display("FAIL hit_we got %b exp 0000", w); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (HIT !== 1'b0) $display("FAIL hit_pulse got %0b exp 0", HIT); else pass_cnt++;
  endtask

  task automatic test_fill_order();
    logic rl, h, m, r; logic [1:0] sl; logic [3:0] w;
    logic [3:0] exp_we;
    for (int i = 0; i < 4; i++) begin
      do_lookup(4'd5, 20'hA0001 + i, '0, '0, '0, '0, 1'b0, rl, h, m, sl, w);
      total_cnt++; if (m !== 1'b1 || sl !== i[1:0]) $display("FAIL fill_order_%0d MISS=%0b SEL=%0d exp 1/%0d", i, m, sl, i); else pass_cnt++;
      if (i == 0) begin
        @(negedge CLK); REQ_VALID = 1'b1;
        @(negedge CLK); REQ_VALID = 1'b0;
        total_cnt++; if (READY !== 1'b0 || MISS !== 1'b0) $display("FAIL req_ignored READY=%0b MISS=%0b exp 0/0", READY, MISS); else pass_cnt++;
      end
      do_fill(1'b0, w, r);
      exp_we = 4'b0001 << i;
      total_cnt++; if (w !== exp_we) $display("FAIL fill_we_%0d got %b exp %b", i, w, exp_we); else pass_cnt++;
    end
    do_lookup(4'd5, 20'hA0005, '0, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd0) $display("FAIL plru_fifth MISS=%0b SEL=%0d exp 1/0", m, sl); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0001) $display("FAIL plru_fifth_we got %b exp 0001", w); else pass_cnt++;
  endtask

  task automatic test_plru();
    logic rl, h, m, r; logic [1:0] sl; logic [3:0] w;
    do_lookup(4'd5, 20'hA0005, 20'hA0005, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || sl !== 2'd0) $display("FAIL plru_hit0 HIT=%0b SEL=%0d exp 1/0", h, sl); else pass_cnt++;
    do_lookup(4'd5, 20'hB0001, '0, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd2) $display("FAIL plru_victim2 MISS=%0b SEL=%0d exp 1/2", m, sl); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0100) $display("FAIL plru_fill2 got %b exp 0100", w); else pass_cnt++;
    do_lookup(4'd5, 20'hB0001, '0, '0, 20'hB0001, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || sl !== 2'd2) $display("FAIL plru_hit2 HIT=%0b SEL=%0d exp 1/2", h, sl); else pass_cnt++;
    do_lookup(4'd5, 20'hB0002, '0, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd1) $display("FAIL plru_victim1 MISS=%0b SEL=%0d exp 1/1", m, sl); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0010) $display("FAIL plru_fill1 got %b exp 0010", w); else pass_cnt++;
    do_lookup(4'd5, 20'hC0000, '0, 20'hC0000, 20'hC0000, 20'hC0000, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || sl !== 2'd1) $display("FAIL lowest_match HIT=%0b SEL=%0d exp 1/1", h, sl); else pass_cnt++;
  endtask

  task automatic test_inv();
    logic rl, h, m, r; logic [1:0] sl; logic [3:0] w;
    do_lookup(4'd5, 20'hC0000, 20'hC0000, '0, '0, '0, 1'b1, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || sl !== 2'd0) $display("FAIL inv_lookup_preclear HIT=%0b SEL=%0d exp 1/0", h, sl); else pass_cnt++;
    do_lookup(4'd5, 20'hC0000, 20'hC0000, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd0) $display("FAIL inv_cleared MISS=%0b SEL=%0d exp 1/0", m, sl); else pass_cnt++;
    do_fill(1'b1, w, r);
    total_cnt++; if (w !== 4'b0000 || r !== 1'b1) $display("FAIL inv_fill_prio WE=%b READY=%0b exp 0000/1", w, r); else pass_cnt++;
    do_lookup(4'd5, 20'hC0000, 20'hC0000, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd0) $display("FAIL inv_after_miss MISS=%0b SEL=%0d exp 1/0", m, sl); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0001) $display("FAIL inv_refill got %b exp 0001", w); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0000 || r !== 1'b1) $display("FAIL fill_idle_ignored WE=%b READY=%0b exp 0000/1", w, r); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic rl, h, m, r; logic [1:0] sl; logic [3:0] w;
    do_lookup(4'd7, 20'h0ABCD, '0, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    do_fill(1'b0, w, r);
    do_lookup(4'd7, 20'h0ABCD, 20'h0ABCD, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (h !== 1'b1 || sl !== 2'd0) $display("FAIL abort_prehit HIT=%0b SEL=%0d exp 1/0", h, sl); else pass_cnt++;
    do_lookup(4'd7, 20'h0DCBA, 20'h0ABCD, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || sl !== 2'd1) $display("FAIL abort_miss MISS=%0b SEL=%0d exp 1/1", m, sl); else pass_cnt++;
    mon_we = 1'b1;
    @(negedge CLK);
    FILL_DONE = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    total_cnt++; if (READY !== 1'b1 || SEL !== 2'd0 || WE !== 4'b0000) $display("FAIL abort_reset READY=%0b SEL=%0d WE=%b exp 1/0/0000", READY, SEL, WE); else pass_cnt++;
    @(negedge CLK);
    RST_N = 1'b1;
    FILL_DONE = 1'b1;
    @(negedge CLK);
    FILL_DONE = 1'b0;
    do_lookup(4'd7, 20'h0ABCD, 20'h0ABCD, '0, '0, '0, 1'b0, rl, h, m, sl, w);
    total_cnt++; if (m !== 1'b1 || h !== 1'b0 || sl !== 2'd0) $display("FAIL abort_valid_cleared MISS=%0b HIT=%0b SEL=%0d exp 1/0/0", m, h, sl); else pass_cnt++;
    @(negedge CLK);
    mon_we = 1'b0;
    total_cnt++; if (we_seen !== 0) $display("FAIL abort_no_we got %0d pulses exp 0", we_seen); else pass_cnt++;
    do_fill(1'b0, w, r);
    total_cnt++; if (w !== 4'b0001) $display("FAIL abort_refill got %b exp 0001", w); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_fill_order();
    test_plru();
    test_inv();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tag_way_ctrl.md
TAG_WAY_CTRL -- requirements
Module: tag_way_ctrl

Interface
REQ-001 The block SHALL expose parameter TAG_W, default 20, meaning the tag width in bits; it SHALL equal the k of the downstream 4-to-1 tag mux.
REQ-002 The block SHALL expose parameter SET_W, default 4, meaning the set-index width (2**SET_W sets).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, named as listed below.
REQ-004 CLK  in  1  the single clock; all state updates occur on its rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 REQ_VALID  in  1  lookup request present.
REQ-007 REQ_TAG  in  TAG_W  request tag.
REQ-008 REQ_SET  in  SET_W  request set index; also drives the tag-bank read address.
REQ-009 TAG0, TAG1, TAG2, TAG3  in  TAG_W each  tag-bank read data, valid one cycle after REQ_SET is presented.
REQ-010 FILL_DONE  in  1  refill of the pending miss line complete.
REQ-011 INV  in  1  invalidate all ways of all sets.
REQ-012 READY  out  1  block can accept a request.
REQ-013 HIT  out  1  one-cycle lookup-hit pulse.
REQ-014 MISS  out  1  one-cycle lookup-miss pulse.
REQ-015 SEL  out  2  way select to the tag mux: hit way on hit, victim way on miss.
REQ-016 WE  out  4  one-hot tag-bank write enable, one pulse per completed fill.

Function
REQ-017 The FSM SHALL have three states: IDLE, LOOKUP and MISS_WAIT; READY SHALL be 1 only in IDLE.
REQ-018 In IDLE, REQ_VALID=1 SHALL capture REQ_TAG/REQ_SET into internal registers and move the FSM to LOOKUP on the next edge.
REQ-019 In LOOKUP, for each way w, match[w] SHALL equal valid[set][w] AND (TAGw == captured tag).
REQ-020 If any match is set in LOOKUP, the block SHALL assert HIT for one cycle, set SEL to the lowest-index matching way, update PLRU and return to IDLE.
REQ-021 If no match is set in LOOKUP, the block SHALL assert MISS for one cycle, set SEL to the victim way and enter MISS_WAIT.
REQ-022 The victim SHALL be the lowest-index invalid way of the set; if all four ways are valid, it SHALL be the PLRU victim.
REQ-023 Each set SHALL hold 3 PLRU bits b0/b1/b2; the PLRU victim is b0=0 -> (b1=0 ? way0 : way1), and b0=1 -> (b2=0 ? way2 : way3).
REQ-024 On a hit or a fill of way w, the PLRU bits SHALL be updated as follows: w=0 -> b0=1,b1=1; w=1 -> b0=1,b1=0; w=2 -> b0=0,b2=1; w=3 -> b0=0,b2=0; unmentioned bits are unchanged.
REQ-025 SEL SHALL hold the victim way throughout MISS_WAIT; in IDLE, SEL SHALL hold its last value.
REQ-026 In MISS_WAIT, FILL_DONE=1 SHALL pulse WE[victim] for one cycle, set valid[set][victim], update PLRU and return to IDLE.
REQ-027 INV=1 in any state SHALL clear all valid bits on that edge.
REQ-028 If INV=1 in MISS_WAIT, the block SHALL return to IDLE with no WE pulse, and INV SHALL take priority over a simultaneous FILL_DONE.
REQ-029 If INV=1 in LOOKUP, the lookup SHALL complete using the pre-clear valid bits.
REQ-030 REQ_VALID outside IDLE SHALL be ignored.
REQ-031 FILL_DONE outside MISS_WAIT SHALL be ignored.
REQ-032 HIT, MISS and WE SHALL never be asserted in the same cycle.

Reset
REQ-033 While RST_N=0, the FSM SHALL be in IDLE and all outputs SHALL be READY=1, HIT=0, MISS=0, WE=0, SEL=0.
REQ-034 While RST_N=0, all valid bits and PLRU bits SHALL be cleared.
REQ-035 Reset assertion mid-lookup or mid-miss SHALL abort the operation with no WE pulse.
REQ-036 The first request SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-037 Cold miss: after reset, request set=3, tag=0x12345 -> MISS pulse, SEL=0; then FILL_DONE -> WE=4'b0001, READY=1 next cycle.
REQ-038 Hit: repeat the request with TAG0=0x12345 -> HIT two cycles after acceptance, SEL=0, no WE.
REQ-039 Fill order: four distinct-tag misses to set 5 -> victims 0,1,2,3 in order; a fifth miss -> PLRU victim 0 (b0=0,b1=0 after filling way 3).
REQ-040 PLRU: all ways valid, hit way 0, then a miss -> victim way 2; hit way 2, then a miss -> victim way 1.
REQ-041 INV+FILL_DONE in the same cycle during MISS_WAIT -> IDLE, WE=0; the next lookup misses with SEL=0.
REQ-042 RST_N pulsed low during MISS_WAIT -> READY=1, SEL=0, all valid bits cleared, and no WE pulse at any time.
